// File: rtl/read_return_reorder.sv
// Collects out-of-order read completions by entry index and releases them in allocation order.
// Registered state drives out_valid (one cycle after the completion lands); out_ready=0 holds the head slot.
module read_return_reorder #(
    parameter int data_width       = 16,
    parameter int read_entries     = 64,
    parameter int read_entries_log = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_req,
    output logic                        alloc_ready,
    output logic [read_entries_log-1:0] alloc_index,
    input  logic                        in_valid,
    input  logic                        in_type,
    input  logic [data_width-1:0]       in_data,
    input  logic [read_entries_log-1:0] in_index,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [data_width-1:0]       out_data,
    output logic [read_entries_log-1:0] out_index,
    output logic                        wr_ack,
    output logic                        err
);

    localparam int PW = read_entries_log + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(read_entries);

    logic [read_entries-1:0] alloc_q, alloc_d;
    logic [read_entries-1:0] done_q, done_d;
    logic [data_width-1:0]   data_q [read_entries];
    logic [data_width-1:0]   data_d [read_entries];
    logic [PW-1:0]           head_q, head_d;
    logic [PW-1:0]           tail_q, tail_d;
    logic                    wr_ack_q, wr_ack_d;
    logic                    err_q, err_d;

    logic [PW-1:0]               count;
    logic [read_entries_log-1:0] head_idx;
    logic [read_entries_log-1:0] tail_idx;
    logic                        alloc_fire;
    logic                        pop;

    assign count       = tail_q - head_q;
    assign head_idx    = head_q[read_entries_log-1:0];
    assign tail_idx    = tail_q[read_entries_log-1:0];
    assign alloc_ready = (count != FULL_CNT);
    assign alloc_index = tail_idx;
    assign alloc_fire  = alloc_req && alloc_ready;
    assign out_valid   = done_q[head_idx];
    assign out_data    = data_q[head_idx];
    assign out_index   = head_idx;
    assign pop         = out_valid && out_ready;
    assign wr_ack      = wr_ack_q;
    assign err         = err_q;

    // Completion checks use pre-edge alloc/done, so a completion racing its own allocation is an error.
    always_comb begin
        alloc_d  = alloc_q;
        done_d   = done_q;
        data_d   = data_q;
        head_d   = head_q;
        tail_d   = tail_q;
        err_d    = err_q;
        wr_ack_d = in_valid && in_type;
        if (in_valid && !in_type) begin
            if (alloc_q[in_index] && !done_q[in_index]) begin
                done_d[in_index] = 1'b1;
                data_d[in_index] = in_data;
            end else begin
                err_d = 1'b1;
            end
        end
        if (alloc_fire) begin
            alloc_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + 1'b1;
        end
        if (pop) begin
            alloc_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q  <= '0;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            wr_ack_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            alloc_q  <= alloc_d;
            done_q   <= done_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            wr_ack_q <= wr_ack_d;
            err_q    <= err_d;
        end
    end

    // Payload storage is qualified by done bits, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_read_return_reorder.sv
// Directed bench for read_return_reorder: ordering, full/wrap, backpressure, write acks, errors, reset.
module tb_read_return_reorder;

    localparam int DW = 16;
    localparam int N  = 64;
    localparam int L  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req;
    logic          alloc_ready;
    logic [L-1:0]  alloc_index;
    logic          in_valid;
    logic          in_type;
    logic [DW-1:0] in_data;
    logic [L-1:0]  in_index;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [L-1:0]  out_index;
    logic          wr_ack;
    logic          err;

    int checks = 0;
    int errors = 0;

    read_return_reorder #(
        .data_width      (DW),
        .read_entries    (N),
        .read_entries_log(L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_ready(alloc_ready),
        .alloc_index(alloc_index),
        .in_valid   (in_valid),
        .in_type    (in_type),
        .in_data    (in_data),
        .in_index   (in_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .wr_ack     (wr_ack),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic complete(input logic [L-1:0] idx, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_type  = 1'b0;
        in_index = idx;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1; alloc_req = 1'b0; in_valid = 1'b0; in_type = 1'b0;
        in_data = '0; in_index = '0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_index", 32'(alloc_index), 32'd0);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_out_index",   32'(out_index),   32'd0);
        check("rst_wr_ack",      32'(wr_ack),      32'd0);
        check("rst_err",         32'(err),         32'd0);

        // In-order release of completions arriving 2, 0, 1
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_alloc_index", 32'(alloc_index), 32'(i));
            step();
        end
        alloc_req = 1'b0;
        out_ready = 1'b1;
        complete(6'd2, 16'hCCCC);
        step();
        check("t1_no_early_out", 32'(out_valid), 32'd0);
        complete(6'd0, 16'hAAAA);
        step();
        check("t1_v0", 32'(out_valid), 32'd1);
        check("t1_d0", 32'(out_data),  32'hAAAA);
        check("t1_i0", 32'(out_index), 32'd0);
        complete(6'd1, 16'hBBBB);
        step();
        in_valid = 1'b0;
        check("t1_v1", 32'(out_valid), 32'd1);
        check("t1_d1", 32'(out_data),  32'hBBBB);
        check("t1_i1", 32'(out_index), 32'd1);
        step();
        check("t1_v2", 32'(out_valid), 32'd1);
        check("t1_d2", 32'(out_data),  32'hCCCC);
        check("t1_i2", 32'(out_index), 32'd2);
        step();
        check("t1_drained", 32'(out_valid), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // Fill all 64 slots, backpressure on head, then wrap
        out_ready = 1'b0;
        do_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < N; i++) step();
        check("t2_full_ready", 32'(alloc_ready), 32'd0);
        check("t2_full_index", 32'(alloc_index), 32'd0);
        step();
        check("t2_ignored_index", 32'(alloc_index), 32'd0);
        check("t2_ignored_err",   32'(err),         32'd0);
        complete(6'd0, 16'h1234);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(out_valid),   32'd1);
            check("t3_hold_data",  32'(out_data),    32'h1234);
            check("t3_hold_index", 32'(out_index),   32'd0);
            check("t3_hold_full",  32'(alloc_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t3_pop_head",  32'(out_index),   32'd1);
        check("t3_pop_valid", 32'(out_valid),   32'd0);
        check("t2_ready_after_pop", 32'(alloc_ready), 32'd1);
        check("t2_wrap_index", 32'(alloc_index), 32'd0);
        step();
        alloc_req = 1'b0;
        check("t2_refull_ready", 32'(alloc_ready), 32'd0);
        check("t2_refull_index", 32'(alloc_index), 32'd1);

        // Write completion acks one cycle later and stores nothing
        do_reset();
        alloc_req = 1'b1;
        step();
        step();
        alloc_req = 1'b0;
        complete(6'd1, 16'hB1B1);
        step();
        check("t4_ack_idle", 32'(wr_ack), 32'd0);
        in_type  = 1'b1;
        in_index = 6'd0;
        in_data  = 16'hDEAD;
        step();
        check("t4_ack_pulse", 32'(wr_ack),    32'd1);
        check("t4_no_store",  32'(out_valid), 32'd0);
        complete(6'd0, 16'hA0A0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t4_ack_done", 32'(wr_ack),   32'd0);
        check("t4_d0",       32'(out_data), 32'hA0A0);
        check("t4_v0",       32'(out_valid), 32'd1);
        step();
        check("t4_d1", 32'(out_data),  32'hB1B1);
        check("t4_i1", 32'(out_index), 32'd1);
        step();
        out_ready = 1'b0;
        check("t4_err", 32'(err), 32'd0);

        // Unallocated and duplicate completions set sticky err
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        complete(6'd5, 16'h5555);
        step();
        check("t5_unalloc_err", 32'(err),       32'd1);
        check("t5_unalloc_val", 32'(out_valid), 32'd0);
        complete(6'd2, 16'h2222);
        step();
        check("t5_d2", 32'(out_data), 32'h2222);
        complete(6'd2, 16'h9999);
        step();
        in_valid = 1'b0;
        step();
        step();
        check("t5_dup_err",  32'(err),       32'd1);
        check("t5_dup_data", 32'(out_data),  32'h2222);
        check("t5_dup_val",  32'(out_valid), 32'd1);

        // Reset with 10 entries in flight discards everything
        do_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < 10; i++) step();
        alloc_req = 1'b0;
        complete(6'd0, 16'h0F0F);
        step();
        complete(6'd20, 16'h0000);
        step();
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_err",   32'(err),       32'd1);
        in_type   = 1'b1;
        alloc_req = 1'b1;
        rst       = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; in_type = 1'b0; alloc_req = 1'b0;
        check("t6_valid", 32'(out_valid),   32'd0);
        check("t6_index", 32'(alloc_index), 32'd0);
        check("t6_ready", 32'(alloc_ready), 32'd1);
        check("t6_err",   32'(err),         32'd0);
        check("t6_ack",   32'(wr_ack),      32'd0);
        step();
        check("t6_ack_after", 32'(wr_ack),    32'd0);
        check("t6_valid_after", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
